// File: rtl/pht_pkg.sv
// pht_pkg: shared counter encoding and FSM states for the bimodal pattern history table
package pht_pkg;
  typedef logic [1:0] pht_ctr_t;
  localparam pht_ctr_t PHT_SNT      = 2'b00;
  localparam pht_ctr_t PHT_WNT      = 2'b01;
  localparam pht_ctr_t PHT_WT       = 2'b10;
  localparam pht_ctr_t PHT_ST       = 2'b11;
  localparam pht_ctr_t PHT_INIT_VAL = PHT_WNT;
  typedef enum logic {PHT_INIT, PHT_READY} pht_fsm_e;
endpackage

// File: rtl/pht_sat_step.sv
// pht_sat_step: combinational 2-bit saturating counter step and resulting prediction
module pht_sat_step
  import pht_pkg::*;
(
  input  pht_ctr_t i_cur,
  input  logic     i_taken,
  output pht_ctr_t o_next,
  output logic     o_pred
);
  assign o_next = i_taken ? ((i_cur == PHT_ST) ? PHT_ST : i_cur + 2'd1)
                          : ((i_cur == PHT_SNT) ? PHT_SNT : i_cur - 2'd1);
  assign o_pred = o_next[1];
endmodule

// File: rtl/bimodal_pht.sv
// bimodal_pht: bimodal predictor table with init sweep, 2-stage update RMW and forwarding (optional PHT_STATS_EN counters)
module bimodal_pht
  import pht_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_lookup_vld,
  input  logic [PC_W-1:0] i_lookup_pc,
  output logic            o_pred_vld,
  output logic            o_pred_taken,
  output logic            o_ready,
  input  logic            i_upd_vld,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken
`ifdef PHT_STATS_EN
  ,
  output logic [31:0]     o_upd_cnt,
  output logic [31:0]     o_flip_cnt
`endif
);
  localparam int DEPTH = 1 << INDEX_W;
  pht_ctr_t            r_tbl [DEPTH];
  pht_fsm_e            r_fsm;
  logic [INDEX_W-1:0]  r_ptr;
  logic                r_u2_vld;
  logic                r_u2_taken;
  logic [INDEX_W-1:0]  r_u2_idx;
  pht_ctr_t            r_u2_cur;
  logic                w_ready;
  logic [INDEX_W-1:0]  w_lk_idx;
  logic [INDEX_W-1:0]  w_upd_idx;
  pht_ctr_t            w_u2_next;
  logic                w_u2_pred;
  pht_ctr_t            w_u1_cur;
  pht_ctr_t            w_lk_ctr;
  logic                w_unused;

  assign w_ready   = (r_fsm == PHT_READY);
  assign o_ready   = w_ready;
  assign w_lk_idx  = i_lookup_pc[INDEX_W+1:2];
  assign w_upd_idx = i_upd_pc[INDEX_W+1:2];
  assign w_unused  = ^{i_lookup_pc, i_upd_pc, w_u2_pred};

  // U2 write value is forwarded to both the U1 read and a same-cycle lookup (write-first)
  assign w_u1_cur = (r_u2_vld && r_u2_idx == w_upd_idx) ? w_u2_next : r_tbl[w_upd_idx];
  assign w_lk_ctr = (r_u2_vld && r_u2_idx == w_lk_idx) ? w_u2_next : r_tbl[w_lk_idx];

  pht_sat_step u_step (
    .i_cur   (r_u2_cur),
    .i_taken (r_u2_taken),
    .o_next  (w_u2_next),
    .o_pred  (w_u2_pred)
  );

  // init sweep walks every entry once, then stays READY until reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm <= PHT_INIT;
      r_ptr <= '0;
    end else if (r_fsm == PHT_INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == {INDEX_W{1'b1}}) r_fsm <= PHT_READY;
    end
  end

  // U1 -> U2 pipeline register; requests outside READY are dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_u2_vld   <= 1'b0;
      r_u2_taken <= 1'b0;
      r_u2_idx   <= '0;
      r_u2_cur   <= PHT_SNT;
    end else begin
      r_u2_vld   <= i_upd_vld & w_ready;
      r_u2_taken <= i_upd_taken;
      r_u2_idx   <= w_upd_idx;
      r_u2_cur   <= w_u1_cur;
    end
  end

  // registered prediction; direction holds when no valid lookup
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pred_vld   <= 1'b0;
      o_pred_taken <= 1'b0;
    end else begin
      o_pred_vld <= i_lookup_vld & w_ready;
      if (i_lookup_vld && w_ready) o_pred_taken <= w_lk_ctr[1];
    end
  end

  // single write port: sweep writes while initialising, U2 writes once ready
  always_ff @(posedge i_clk) begin
    if (!w_ready) r_tbl[r_ptr] <= PHT_INIT_VAL;
    else if (r_u2_vld) r_tbl[r_u2_idx] <= w_u2_next;
  end

`ifdef PHT_STATS_EN
  // saturating update and direction-flip counters, counted in U2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_upd_cnt  <= '0;
      o_flip_cnt <= '0;
    end else if (r_u2_vld) begin
      o_upd_cnt  <= o_upd_cnt + {31'd0, (o_upd_cnt != '1)};
      o_flip_cnt <= o_flip_cnt + {31'd0, (o_flip_cnt != '1) && (w_u2_pred != r_u2_cur[1])};
    end
  end
`endif
endmodule

// File: doc/bimodal_pht.md
Name: bimodal_pht

Overview:
- Pattern history table for the bimodal branch predictor: 2^INDEX_W entries, each a 2-bit saturating counter.
- Read side: the IF stage looks up a PC and gets a registered taken/not-taken prediction.
- Write side: the EX stage sends resolved outcomes, applied by a 2-stage read-modify-write pipeline with forwarding.
- After reset, an internal init sweep loads every entry to weak-not-taken.

Parameters:
- PC_W, 32, width of program counter inputs.
- INDEX_W, 8, index width; table depth = 2^INDEX_W entries.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_lookup_vld  input  1  IF lookup request this cycle.
- i_lookup_pc  input  PC_W  PC of the fetched instruction.
- o_pred_vld  output  1  prediction valid (registered).
- o_pred_taken  output  1  predicted direction (counter MSB).
- o_ready  output  1  table initialised; lookups and updates accepted.
- i_upd_vld  input  1  resolved-branch update request.
- i_upd_pc  input  PC_W  PC of the resolved branch.
- i_upd_taken  input  1  actual branch outcome.

Behaviour:
- Index: idx = pc[INDEX_W+1:2] for both lookup and update.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = MSB.
- Reset (async assert): FSM = INIT, sweep pointer = 0, o_ready = 0, o_pred_vld = 0, o_pred_taken = 0, update pipeline valids = 0.
- FSM INIT:
  - Writes 01 to entry[ptr] each cycle; ptr increments by 1.
  - When ptr = 2^INDEX_W-1 is written, moves to READY. Sweep takes exactly 2^INDEX_W cycles.
  - Lookups and updates arriving in INIT are dropped: o_pred_vld stays 0, no state change.
- FSM READY: o_ready = 1. No exit except reset.
- Reset asserted mid-sweep or mid-update: everything aborts; the sweep restarts from 0 after release.
- Lookup: table read at cycle N; o_pred_vld/o_pred_taken registered at N+1 (latency 1). o_pred_vld = i_lookup_vld & ready, delayed one cycle. o_pred_taken holds its last value when o_pred_vld = 0.
- Update pipeline:
  - U1 (cycle N): capture idx/taken; read entry[idx].
  - U2 (cycle N+1): next = saturating step (taken: +1, max 11; not taken: -1, min 00); write entry[idx] at end of N+1.
  - Throughput: one update per cycle, no backpressure.
- Forwarding:
  - U1 read whose index matches U2's index uses U2's next value, not the array value. Back-to-back updates to one entry must step twice.
  - A lookup in the same cycle as a U2 write to the same index returns the newly written value's MSB (write-first).
- Saturation: 11 plus taken stays 11; 00 plus not-taken stays 00.
- Lookup and update to different indices in the same cycle are independent.

Optional Feature:
- Macro PHT_STATS_EN.
- Defined: adds outputs o_upd_cnt[31:0] (accepted updates) and o_flip_cnt[31:0] (updates where the written MSB differs from the old MSB).
  - Both counters count in U2, reset to 0, saturate at 0xFFFF_FFFF.
- Undefined: no ports, no counters, no added logic.

Decomposition:
- Package pht_pkg:
  - typedef pht_ctr_t (logic [1:0]).
  - Constants PHT_SNT/PHT_WNT/PHT_WT/PHT_ST, PHT_INIT_VAL = PHT_WNT.
  - FSM enum pht_fsm_e {PHT_INIT, PHT_READY}.
- One sub-module, pht_sat_step: combinational saturating next-counter function (inputs cur, taken; outputs next, pred), instantiated in U2.

Test Plan:
- Reset with INDEX_W=8 -> o_ready=0 for exactly 256 cycles after release, then 1. Lookup of any PC afterwards -> o_pred_vld=1, o_pred_taken=0 one cycle later.
- Lookup during INIT (cycle 10) -> o_pred_vld stays 0. Update during INIT -> entry still 01 after READY.
- Two taken updates on consecutive cycles to PC 0x0000_0040, then lookup -> counter 11, o_pred_taken=1. Two more taken updates keep 11. Three not-taken updates -> 00, o_pred_taken=0.
- Taken update to PC 0x100 with a lookup of 0x100 in the U2 write cycle -> o_pred_taken=1 (write-first bypass). Lookup of 0x104 in the same cycle -> 0.
- Reset asserted at sweep cycle 100 -> o_ready drops immediately; the full 256-cycle sweep reruns. Entries written before reset still read 01.
- PHT_STATS_EN defined: updates T, T, N, N to one PC -> o_upd_cnt=4, o_flip_cnt=2 (01->10 and 10->01 flips).
